// File: rtl/modadd_if.sv
// Operand/result handshake and K configuration bundle for the modular adder.
// No latency or backpressure of its own; flow control is in_valid/in_ready and out_valid/out_ready.
interface modadd_if #(
  parameter int N_BITS = 7
);
  logic              cfg_we;
  logic [N_BITS-1:0] cfg_k;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_a;
  logic [N_BITS-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_sum;
  logic              busy;

  modport master (
    output cfg_we, cfg_k, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  cfg_we, cfg_k, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/modadd_seq_ctrl.sv
// (A+B) mod (2^N_BITS-K) via iterative Kogge-Stone prefix; latency LEVELS+3 edges, one op in flight.
// in_ready only in IDLE; result holds in DONE until out_ready, stalling indefinitely.
module modadd_seq_ctrl #(
  parameter int N_BITS = 7
) (
  input  logic     clk,
  input  logic     rst,
  modadd_if.slave  io
);
  localparam int LEVELS = $clog2(N_BITS);
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);

  typedef enum logic [2:0] {IDLE, PRE, PREFIX, POST, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] k_reg, op_a, op_b, op_k;
  // *_q: plain A+B chain; *k_q: enveloped A+B+K chain
  logic [N_BITS-1:0] g_q, p_q, h_q, gk_q, pk_q, hk_q;
  logic              ov_q;
  logic [LVL_W-1:0]  lvl_q;
  logic              out_valid_q;
  logic [N_BITS-1:0] out_sum_q;

  // Carry-save compression of A+B+K: a_env is the sum row, b_env the carry row.
  logic [N_BITS-1:0] x_ab, a_env, b_env, b_sh;
  assign x_ab  = op_a ^ op_b;
  assign a_env = x_ab ^ op_k;
  assign b_env = (op_k & (op_a | op_b)) | (~op_k & op_a & op_b);
  assign b_sh  = b_env << 1;

  logic [N_BITS-1:0] low_mask, g_nx, p_nx, gk_nx, pk_nx;
  always_comb begin
    // Bits below the span keep P; G holds automatically since the shifted-in G is zero.
    low_mask = ~({N_BITS{1'b1}} << (1 << lvl_q));
    g_nx     = g_q  | (p_q  & (g_q  << (1 << lvl_q)));
    p_nx     = p_q  & ((p_q  << (1 << lvl_q)) | low_mask);
    gk_nx    = gk_q | (pk_q & (gk_q << (1 << lvl_q)));
    pk_nx    = pk_q & ((pk_q << (1 << lvl_q)) | low_mask);
  end

  logic [N_BITS-1:0] s1, s2;
  logic              c2;
  assign s1 = h_q  ^ (g_q  << 1);
  assign s2 = hk_q ^ (gk_q << 1);
  assign c2 = ov_q | gk_q[N_BITS-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.in_valid) state_d = PRE;
      PRE:     state_d = PREFIX;
      PREFIX:  if (lvl_q == LVL_LAST) state_d = POST;
      POST:    state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_reg       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_k        <= '0;
      g_q         <= '0;
      p_q         <= '0;
      h_q         <= '0;
      gk_q        <= '0;
      pk_q        <= '0;
      hk_q        <= '0;
      ov_q        <= 1'b0;
      lvl_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // op_k samples the old k_reg, so a same-cycle cfg_we only affects later operations
          if (io.cfg_we) k_reg <= io.cfg_k;
          if (io.in_valid) begin
            op_a <= io.in_a;
            op_b <= io.in_b;
            op_k <= k_reg;
          end
        end
        PRE: begin
          g_q   <= op_a & op_b;
          p_q   <= op_a | op_b;
          h_q   <= x_ab;
          gk_q  <= a_env & b_sh;
          pk_q  <= a_env | b_sh;
          hk_q  <= a_env ^ b_sh;
          ov_q  <= b_env[N_BITS-1];
          lvl_q <= '0;
        end
        PREFIX: begin
          g_q   <= g_nx;
          p_q   <= p_nx;
          gk_q  <= gk_nx;
          pk_q  <= pk_nx;
          lvl_q <= lvl_q + 1'b1;
        end
        POST: begin
          out_sum_q   <= c2 ? s2 : s1;
          out_valid_q <= 1'b1;
        end
        DONE: if (io.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = out_sum_q;
endmodule

// File: tb/tb_modadd_seq_ctrl.sv
// Directed bench for modadd_seq_ctrl with hand-computed sums for several moduli.
// Covers latency, back-to-back issue, K load collisions, output stall and mid-op reset.
module tb_modadd_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  modadd_if #(.N_BITS(7)) io();

  modadd_seq_ctrl #(.N_BITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  // Drives one operation with out_ready high; returns at the negedge after the output handshake.
  task automatic run_op(input logic [6:0] a, input logic [6:0] b, output logic [6:0] sum,
                        output int lat, output bit rdy_ok, output bit tmo);
    int guard;
    guard = 0; lat = 0; rdy_ok = 1'b1; tmo = 1'b0; sum = '0;
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.in_a      = a;
    io.in_b      = b;
    while (!io.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.cfg_we   = 1'b0;
    lat = 1;
    while (!io.out_valid && guard < 50) begin
      if (io.in_ready) rdy_ok = 1'b0;
      @(negedge clk);
      lat++;
      guard++;
    end
    if (!io.out_valid) tmo = 1'b1;
    if (io.in_ready) rdy_ok = 1'b0;
    sum = io.out_sum;
    @(negedge clk);
  endtask

  task automatic set_k(input logic [6:0] k);
    io.cfg_we = 1'b1; io.cfg_k = k;
    @(negedge clk);
    io.cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
    n_tests++; if (io.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", io.busy); end
    n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
    n_tests++; if (io.out_sum !== 7'd0) begin n_fail++; $display("FAIL reset_out_sum got %0d want 0", io.out_sum); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [6:0] s; int lat; bit rok, tmo;
    set_k(7'd20);
    run_op(7'd69, 7'd45, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd6) begin n_fail++; $display("FAIL basic_sum got %0d want 6 (timeout=%b)", s, tmo); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6 edges", lat); end
    n_tests++; if (!rok) begin n_fail++; $display("FAIL basic_in_ready got high-during-op want low"); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] s; int lat; bit rok, tmo;
    run_op(7'd10, 7'd20, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd30 || !rok) begin n_fail++; $display("FAIL b2b_first got %0d rdy_ok=%b want 30 rdy_ok=1", s, rok); end
    n_tests++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got in_ready=%b out_valid=%b want 1/0", io.in_ready, io.out_valid); end
    run_op(7'd107, 7'd107, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd106) begin n_fail++; $display("FAIL b2b_second_sum got %0d want 106", s); end
    n_tests++; if (!rok || lat != 6) begin n_fail++; $display("FAIL b2b_second_timing got rdy_ok=%b lat=%0d want 1/6", rok, lat); end
  endtask

  task automatic test_reset_mid;
    logic [6:0] s; int lat; bit rok, tmo; bit pulsed;
    io.out_ready = 1'b1;
    io.in_valid = 1'b1; io.in_a = 7'd69; io.in_b = 7'd45;
    @(posedge clk);
    @(negedge clk); io.in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (io.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", io.busy); end
    rst = 1'b1;
    #1;
    n_tests++; if (io.out_valid !== 1'b0 || io.out_sum !== 7'd0) begin n_fail++; $display("FAIL midrst_outputs got valid=%b sum=%0d want 0/0", io.out_valid, io.out_sum); end
    n_tests++; if (io.in_ready !== 1'b1 || io.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state got in_ready=%b busy=%b want 1/0", io.in_ready, io.busy); end
    @(negedge clk); rst = 1'b0;
    pulsed = 1'b0;
    repeat (10) begin @(negedge clk); if (io.out_valid !== 1'b0) pulsed = 1'b1; end
    n_tests++; if (pulsed) begin n_fail++; $display("FAIL midrst_no_pulse got out_valid pulse want none"); end
    run_op(7'd5, 7'd3, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd8) begin n_fail++; $display("FAIL midrst_fresh_sum got %0d want 8", s); end
    run_op(7'd100, 7'd100, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd72) begin n_fail++; $display("FAIL k0_wrap_sum got %0d want 72", s); end
  endtask

  task automatic test_k1;
    logic [6:0] s; int lat; bit rok, tmo;
    set_k(7'd1);
    run_op(7'd126, 7'd1, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd0) begin n_fail++; $display("FAIL k1_max_sum got %0d want 0", s); end
    run_op(7'd0, 7'd0, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd0) begin n_fail++; $display("FAIL k1_zero_sum got %0d want 0", s); end
  endtask

  task automatic test_cfg_collision;
    logic [6:0] s; int lat; bit rok, tmo;
    set_k(7'd20);
    io.cfg_we = 1'b1; io.cfg_k = 7'd1;
    run_op(7'd69, 7'd45, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd6) begin n_fail++; $display("FAIL collide_old_k got %0d want 6", s); end
    run_op(7'd126, 7'd1, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd0) begin n_fail++; $display("FAIL collide_new_k got %0d want 0", s); end
  endtask

  task automatic test_stall_cfg_busy;
    logic [6:0] s; int lat; bit rok, tmo; bit stable; int guard;
    io.out_ready = 1'b0;
    io.in_valid = 1'b1; io.in_a = 7'd100; io.in_b = 7'd60;
    @(posedge clk);
    @(negedge clk); io.in_valid = 1'b0; io.cfg_we = 1'b1; io.cfg_k = 7'd20;
    @(negedge clk); io.cfg_we = 1'b0;
    guard = 0;
    while (!io.out_valid && guard < 50) begin @(negedge clk); guard++; end
    n_tests++; if (io.out_valid !== 1'b1 || io.out_sum !== 7'd33) begin n_fail++; $display("FAIL stall_sum got valid=%b sum=%0d want 1/33", io.out_valid, io.out_sum); end
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (io.out_valid !== 1'b1 || io.out_sum !== 7'd33 || io.in_ready !== 1'b0) stable = 1'b0;
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL stall_hold got unstable outputs want valid=1 sum=33 in_ready=0"); end
    io.out_ready = 1'b1;
    @(negedge clk); io.out_ready = 1'b0;
    n_tests++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got valid=%b in_ready=%b want 0/1", io.out_valid, io.in_ready); end
    @(negedge clk);
    n_tests++; if (io.out_valid !== 1'b0 || io.busy !== 1'b0) begin n_fail++; $display("FAIL stall_single_hs got valid=%b busy=%b want 0/0", io.out_valid, io.busy); end
    run_op(7'd126, 7'd1, s, lat, rok, tmo);
    n_tests++; if (tmo || s !== 7'd0) begin n_fail++; $display("FAIL busy_cfg_ignored got %0d want 0", s); end
  endtask

  initial begin
    io.cfg_we = 1'b0; io.cfg_k = '0; io.in_valid = 1'b0;
    io.in_a = '0; io.in_b = '0; io.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_k1();
    test_cfg_collision();
    test_stall_cfg_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
